// File: rtl/definitions.sv
// rtl/definitions.sv - shared OVI bus types plus VPU responder dispatch/FSM enums
package definitions;

  localparam int OVI_SBID_WIDTH   = 5;
  localparam int OVI_VSTART_WIDTH = 7;

  typedef struct packed {
    logic                      vill;
    logic [2:0]                vsew;
    logic [OVI_VSTART_WIDTH:0] vl;
  } vcsr_t;

  typedef struct packed {
    logic [31:0]               instr;
    logic [63:0]               scalar_opnd;
    logic [OVI_SBID_WIDTH-1:0] sb_id;
    vcsr_t                     vcsr;
    logic                      valid;
  } vpu_issue_bus;

  typedef struct packed {
    logic [OVI_SBID_WIDTH-1:0] sb_id;
    logic                      next_senior;
    logic                      kill;
  } vpu_dispatch_bus;

  typedef struct packed {
    logic                      valid;
    logic [OVI_SBID_WIDTH-1:0] sb_id;
    logic [63:0]               dest_reg;
    logic [4:0]                fflags;
    logic                      vxsat;
    logic                      illegal;
  } vpu_completed_bus;

  typedef enum logic [1:0] {PENDING = 2'd0, SENIOR = 2'd1, KILLED = 2'd2} disp_status_t;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, COMPLETE = 2'd2} state_t;

  typedef struct packed {
    logic [31:0]               instr;
    logic [63:0]               scalar_opnd;
    logic [OVI_SBID_WIDTH-1:0] sb_id;
    logic [OVI_VSTART_WIDTH:0] vl;
    logic [2:0]                vsew;
    logic                      vill;
  } q_entry_t;

  // Reserved SEW, vill, or an empty vector body on anything other than OP-V.
  function automatic logic entry_illegal(q_entry_t e);
    return e.vill || (e.vsew > 3'b011) || ((e.vl == '0) && (e.instr[6:0] != 7'h57));
  endfunction

endpackage

// File: rtl/ovi_issue_queue.sv
// rtl/ovi_issue_queue.sv - FIFO of issued instructions with per-entry dispatch status
module ovi_issue_queue
  import definitions::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      push,
  input  q_entry_t                  push_entry,
  input  logic                      pop,
  input  logic                      disp_valid,
  input  logic                      disp_kill,
  input  logic [OVI_SBID_WIDTH-1:0] disp_sb_id,
  output logic                      disp_match,
  output q_entry_t                  head_entry,
  output disp_status_t              head_status,
  output logic                      full,
  output logic                      empty
);

  localparam int AW  = $clog2(QDEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] DEPTH_CNT = QDEPTH[AW:0];

  q_entry_t     mem    [QDEPTH];
  disp_status_t status [QDEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, count;
  logic [AW-1:0] idx, midx;
  logic         push_ok, old_match, in_match;
  disp_status_t new_status;

  assign count       = wr_ptr - rd_ptr;
  assign full        = (count == DEPTH_CNT);
  assign empty       = (count == '0);
  assign push_ok     = push && (!full || pop);
  assign new_status  = disp_kill ? KILLED : SENIOR;
  assign head_entry  = mem[rd_ptr[AW-1:0]];
  assign head_status = status[rd_ptr[AW-1:0]];

  // Oldest PENDING match wins; the entry arriving this cycle is only a fallback.
  always_comb begin
    old_match = 1'b0;
    midx      = '0;
    idx       = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      idx = rd_ptr[AW-1:0] + AW'(i);
      if (!old_match && (AW1'(i) < count) && (status[idx] == PENDING) &&
          (mem[idx].sb_id == disp_sb_id)) begin
        old_match = 1'b1;
        midx      = idx;
      end
    end
  end

  assign in_match   = !old_match && push_ok && (push_entry.sb_id == disp_sb_id);
  assign disp_match = disp_valid && (old_match || in_match);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < QDEPTH; i++) status[i] <= PENDING;
    end else begin
      if (push_ok) begin
        status[wr_ptr[AW-1:0]] <= (disp_valid && in_match) ? new_status : PENDING;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (disp_valid && old_match) status[midx] <= new_status;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/ovi_vpu_responder.sv
// rtl/ovi_vpu_responder.sv - VPU-side OVI endpoint: issue queue, exec stub, completions and credits
module ovi_vpu_responder
  import definitions::*;
#(
  parameter int QDEPTH   = 4,
  parameter int EXEC_LAT = 3
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  vpu_issue_bus     VPU_ISSUE,
  input  vpu_dispatch_bus  VPU_DISPATCH,
  output logic             VPU_ISSUE_CREDIT,
  output vpu_completed_bus VPU_COMPLETED,
  output logic             PROTO_ERR
);

  localparam int CW = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             credit_q, err_q;
  vpu_completed_bus comp_q;

  q_entry_t     issue_entry, head_entry;
  disp_status_t head_status;
  logic         disp_valid, disp_match, pop, full, empty;

  assign disp_valid  = VPU_DISPATCH.next_senior || VPU_DISPATCH.kill;
  assign issue_entry = '{instr:       VPU_ISSUE.instr,
                         scalar_opnd: VPU_ISSUE.scalar_opnd,
                         sb_id:       VPU_ISSUE.sb_id,
                         vl:          VPU_ISSUE.vcsr.vl,
                         vsew:        VPU_ISSUE.vcsr.vsew,
                         vill:        VPU_ISSUE.vcsr.vill};

  // Retire on leaving COMPLETE, or drop a killed head straight from IDLE.
  assign pop = (state == COMPLETE) ||
               ((state == IDLE) && !empty && (head_status == KILLED));

  ovi_issue_queue #(.QDEPTH(QDEPTH)) u_queue (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .push        (VPU_ISSUE.valid),
    .push_entry  (issue_entry),
    .pop         (pop),
    .disp_valid  (disp_valid),
    .disp_kill   (VPU_DISPATCH.kill),
    .disp_sb_id  (VPU_DISPATCH.sb_id),
    .disp_match  (disp_match),
    .head_entry  (head_entry),
    .head_status (head_status),
    .full        (full),
    .empty       (empty)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      cnt      <= '0;
      credit_q <= 1'b0;
      err_q    <= 1'b0;
      comp_q   <= '0;
    end else begin
      credit_q <= 1'b0;
      comp_q   <= '0;
      if ((VPU_ISSUE.valid && full && !pop) || (disp_valid && !disp_match)) err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (!empty && (head_status == SENIOR)) begin
            state <= EXEC;
            cnt   <= CW'(EXEC_LAT - 1);
          end else if (!empty && (head_status == KILLED)) begin
            credit_q <= 1'b1;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            state           <= COMPLETE;
            credit_q        <= 1'b1;
            comp_q.valid    <= 1'b1;
            comp_q.sb_id    <= head_entry.sb_id;
            comp_q.dest_reg <= head_entry.scalar_opnd ^ {32'b0, head_entry.instr};
            comp_q.illegal  <= entry_illegal(head_entry);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        COMPLETE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign VPU_ISSUE_CREDIT = credit_q;
  assign VPU_COMPLETED    = comp_q;
  assign PROTO_ERR        = err_q;

endmodule

// File: tb/tb_ovi_vpu_responder.sv
// tb/tb_ovi_vpu_responder.sv - directed table-driven bench for ovi_vpu_responder
module tb_ovi_vpu_responder;
  import definitions::*;

  localparam int QDEPTH   = 4;
  localparam int EXEC_LAT = 3;
  localparam int LAT      = EXEC_LAT + 1;
  localparam int SPACING  = EXEC_LAT + 2;

  logic             CLK = 1'b0;
  logic             RSTN = 1'b0;
  vpu_issue_bus     VPU_ISSUE;
  vpu_dispatch_bus  VPU_DISPATCH;
  logic             VPU_ISSUE_CREDIT;
  vpu_completed_bus VPU_COMPLETED;
  logic             PROTO_ERR;

  ovi_vpu_responder #(.QDEPTH(QDEPTH), .EXEC_LAT(EXEC_LAT)) dut (
    .CLK              (CLK),
    .RSTN             (RSTN),
    .VPU_ISSUE        (VPU_ISSUE),
    .VPU_DISPATCH     (VPU_DISPATCH),
    .VPU_ISSUE_CREDIT (VPU_ISSUE_CREDIT),
    .VPU_COMPLETED    (VPU_COMPLETED),
    .PROTO_ERR        (PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [OVI_SBID_WIDTH-1:0] sb;
    logic [63:0]               dest;
    logic                      ill;
    logic [5:0]                misc;
    int                        cyc;
  } ev_t;

  ev_t comps[$];
  int  credit_cyc[$];
  int  credit_cnt = 0;

  always @(negedge CLK) begin
    if (VPU_COMPLETED.valid)
      comps.push_back('{VPU_COMPLETED.sb_id, VPU_COMPLETED.dest_reg, VPU_COMPLETED.illegal,
                        {VPU_COMPLETED.fflags, VPU_COMPLETED.vxsat}, cyc});
    if (VPU_ISSUE_CREDIT) begin
      credit_cnt = credit_cnt + 1;
      credit_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    VPU_ISSUE    = '0;
    VPU_DISPATCH = '0;
  endtask

  task automatic clear_mon();
    comps.delete();
    credit_cyc.delete();
    credit_cnt = 0;
  endtask

  function automatic vcsr_t mk_vcsr(input logic vill, input logic [2:0] vsew, input logic [7:0] vl);
    vcsr_t v;
    v.vill = vill;
    v.vsew = vsew;
    v.vl   = vl;
    return v;
  endfunction

  task automatic issue(input logic [4:0] sb, input logic [31:0] instr, input logic [63:0] opnd,
                       input vcsr_t vc, input logic senior, input logic kill, output int edge_n);
    VPU_ISSUE.instr          = instr;
    VPU_ISSUE.scalar_opnd    = opnd;
    VPU_ISSUE.sb_id          = sb;
    VPU_ISSUE.vcsr           = vc;
    VPU_ISSUE.valid          = 1'b1;
    VPU_DISPATCH.sb_id       = sb;
    VPU_DISPATCH.next_senior = senior;
    VPU_DISPATCH.kill        = kill;
    tick();
    edge_n = cyc;
    idle_inputs();
  endtask

  task automatic dispatch(input logic [4:0] sb, input logic senior, input logic kill, output int edge_n);
    VPU_DISPATCH.sb_id       = sb;
    VPU_DISPATCH.next_senior = senior;
    VPU_DISPATCH.kill        = kill;
    tick();
    edge_n = cyc;
    idle_inputs();
  endtask

  task automatic wait_comps(input string name, input int n, input int budget);
    int k = 0;
    while (comps.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (comps.size() < n) begin
      failures++;
      $display("FAIL %s_timeout: got %0d completions expected %0d", name, comps.size(), n);
    end
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    repeat (2) tick();
    RSTN = 1'b1;
    tick();
    clear_mon();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] opnd;
    logic [4:0]  sb;
    vcsr_t       vc;
    logic [63:0] exp_dest;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    int d[4];
    vcsr_t vc_ok;
    vc_ok = mk_vcsr(1'b0, 3'd0, 8'd4);

    vecs[0] = '{32'h0000_1057, 64'h5, 5'd3, vc_ok, 64'h0000_1052, 1'b0};
    vecs[1] = '{32'h1234_5678, 64'hFFFF_FFFF_0000_0000, 5'd1, mk_vcsr(1'b0, 3'd0, 8'd0),
                64'hFFFF_FFFF_1234_5678, 1'b1};
    vecs[2] = '{32'h0000_00D7, 64'h0, 5'd2, mk_vcsr(1'b0, 3'd1, 8'd0), 64'h0000_00D7, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 64'hA5A5_A5A5_A5A5_A5A5, 5'd9, mk_vcsr(1'b1, 3'd2, 8'd16),
                64'hA5A5_A5A5_5A5A_5A5A, 1'b1};
    vecs[4] = '{32'h0000_0000, 64'h1, 5'd4, mk_vcsr(1'b0, 3'b100, 8'd1), 64'h1, 1'b1};
    vecs[5] = '{32'h8000_0057, 64'h8000_0000_0000_0000, 5'd31, mk_vcsr(1'b0, 3'b011, 8'd8),
                64'h8000_0000_8000_0057, 1'b0};

    idle_inputs();
    RSTN = 1'b0;
    repeat (2) tick();
    check("rst_valid", VPU_COMPLETED.valid, 0);
    check("rst_credit", VPU_ISSUE_CREDIT, 0);
    check("rst_proto", PROTO_ERR, 0);
    check("rst_dest", VPU_COMPLETED.dest_reg, 0);
    RSTN = 1'b1;
    tick();
    clear_mon();

    for (int i = 0; i < 6; i++) begin
      clear_mon();
      issue(vecs[i].sb, vecs[i].instr, vecs[i].opnd, vecs[i].vc, 1'b1, 1'b0, e);
      wait_comps($sformatf("vec%0d", i), 1, 20);
      repeat (3) tick();
      check($sformatf("vec%0d_ncomp", i), comps.size(), 1);
      check($sformatf("vec%0d_credits", i), credit_cnt, 1);
      if (comps.size() > 0) begin
        check($sformatf("vec%0d_lat", i), comps[0].cyc - e, LAT);
        check($sformatf("vec%0d_sb", i), comps[0].sb, vecs[i].sb);
        check($sformatf("vec%0d_dest", i), comps[0].dest, vecs[i].exp_dest);
        check($sformatf("vec%0d_ill", i), comps[0].ill, vecs[i].exp_ill);
        check($sformatf("vec%0d_misc", i), comps[0].misc, 0);
        if (credit_cyc.size() > 0)
          check($sformatf("vec%0d_credit_cyc", i), credit_cyc[0], comps[0].cyc);
      end
    end
    check("vec_proto", PROTO_ERR, 0);

    // Fill to depth, overflow, then drain in order.
    clear_mon();
    for (int i = 0; i < 4; i++) issue(5'(i), 32'h100 + 32'(i), 64'h0, vc_ok, 1'b0, 1'b0, e);
    check("fill_proto_before", PROTO_ERR, 0);
    issue(5'd4, 32'h104, 64'h0, vc_ok, 1'b0, 1'b0, e);
    check("fill_proto_overflow", PROTO_ERR, 1);
    for (int i = 0; i < 4; i++) dispatch(5'(i), 1'b1, 1'b0, d[i]);
    wait_comps("fill", 4, 60);
    repeat (10) tick();
    check("fill_ncomp", comps.size(), 4);
    check("fill_credits", credit_cnt, 4);
    if (comps.size() == 4) begin
      check("fill_lat0", comps[0].cyc - d[0], LAT);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("fill_sb%0d", i), comps[i].sb, i);
        check($sformatf("fill_dest%0d", i), comps[i].dest, 64'h100 + 64'(i));
        if (i > 0) check($sformatf("fill_gap%0d", i), comps[i].cyc - comps[i-1].cyc, SPACING);
      end
    end
    do_reset();

    // Kill the middle entry; kill beats next_senior when both are set.
    issue(5'd1, 32'h11, 64'h0, vc_ok, 1'b0, 1'b0, e);
    issue(5'd2, 32'h22, 64'h0, vc_ok, 1'b0, 1'b0, e);
    issue(5'd3, 32'h33, 64'h0, vc_ok, 1'b0, 1'b0, e);
    dispatch(5'd2, 1'b1, 1'b1, e);
    dispatch(5'd1, 1'b1, 1'b0, e);
    dispatch(5'd3, 1'b1, 1'b0, e);
    wait_comps("kill", 2, 40);
    repeat (10) tick();
    check("kill_ncomp", comps.size(), 2);
    check("kill_credits", credit_cnt, 3);
    check("kill_proto", PROTO_ERR, 0);
    if (comps.size() == 2) begin
      check("kill_sb_first", comps[0].sb, 1);
      check("kill_sb_second", comps[1].sb, 3);
    end

    // Same-cycle dispatch prefers the older PENDING entry over the incoming one.
    clear_mon();
    issue(5'd2, 32'hAAAA, 64'h0, vc_ok, 1'b0, 1'b0, e);
    issue(5'd2, 32'hBBBB, 64'h0, vc_ok, 1'b1, 1'b0, e);
    wait_comps("older", 1, 20);
    repeat (10) tick();
    check("older_ncomp", comps.size(), 1);
    if (comps.size() > 0) check("older_dest", comps[0].dest, 64'hAAAA);
    dispatch(5'd2, 1'b1, 1'b0, e);
    wait_comps("younger", 2, 20);
    if (comps.size() > 1) check("younger_dest", comps[1].dest, 64'hBBBB);
    check("older_proto", PROTO_ERR, 0);
    repeat (3) tick();

    // Late dispatch: nothing happens until next_senior arrives.
    clear_mon();
    issue(5'd5, 32'h55, 64'h0, vc_ok, 1'b0, 1'b0, e);
    repeat (10) tick();
    check("late_quiet_comp", comps.size(), 0);
    check("late_quiet_credit", credit_cnt, 0);
    dispatch(5'd5, 1'b1, 1'b0, e);
    wait_comps("late", 1, 20);
    if (comps.size() > 0) check("late_lat", comps[0].cyc - e, LAT);
    repeat (3) tick();

    // Unmatched dispatch on an empty queue.
    clear_mon();
    check("unmatched_proto_before", PROTO_ERR, 0);
    dispatch(5'd7, 1'b1, 1'b0, e);
    check("unmatched_proto", PROTO_ERR, 1);
    repeat (10) tick();
    check("unmatched_comp", comps.size(), 0);
    check("unmatched_credit", credit_cnt, 0);

    // Reset while executing with three entries queued.
    clear_mon();
    issue(5'd1, 32'h1, 64'h0, vc_ok, 1'b1, 1'b0, e);
    issue(5'd2, 32'h2, 64'h0, vc_ok, 1'b0, 1'b0, e);
    issue(5'd3, 32'h3, 64'h0, vc_ok, 1'b0, 1'b0, e);
    RSTN = 1'b0;
    #1;
    check("rstexec_proto", PROTO_ERR, 0);
    check("rstexec_valid", VPU_COMPLETED.valid, 0);
    check("rstexec_credit", VPU_ISSUE_CREDIT, 0);
    clear_mon();
    repeat (2) tick();
    RSTN = 1'b1;
    repeat (15) tick();
    check("rstexec_quiet_comp", comps.size(), 0);
    check("rstexec_quiet_credit", credit_cnt, 0);
    issue(5'd6, 32'h66, 64'h0, vc_ok, 1'b1, 1'b0, e);
    wait_comps("rstexec_new", 1, 20);
    repeat (3) tick();
    check("rstexec_new_ncomp", comps.size(), 1);
    check("rstexec_new_credit", credit_cnt, 1);
    if (comps.size() > 0) begin
      check("rstexec_new_sb", comps[0].sb, 6);
      check("rstexec_new_lat", comps[0].cyc - e, LAT);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
